// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: stall, flush and forward-select generation.
// Forwarding compiled in when HZ_FORWARD_EN is defined.
module hazard_scoreboard #(
  parameter int REGW  = 5,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [REGW-1:0]              id_rs1,
  input  logic [REGW-1:0]              id_rs2,
  input  logic                         id_use_rs1,
  input  logic                         id_use_rs2,
  input  logic [REGW-1:0]              id_rd,
  input  logic                         id_regwrite,
  input  logic                         id_is_load,
  input  logic                         ex_redirect,
  output logic                         stall,
  output logic                         flush_d,
  output logic                         flush_e,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_a,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_b,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int FW = $clog2(DEPTH+1);

  logic [DEPTH:1]  entV;
  logic [REGW-1:0] entRd [DEPTH:1];
  logic [DEPTH:1]  matchA;
  logic [DEPTH:1]  matchB;
  logic            useA;
  logic            useB;
  logic            hazard;
  logic            advance;

  assign useA = id_use_rs1 && (id_rs1 != '0);
  assign useB = id_use_rs2 && (id_rs2 != '0);

  // per-stage source/destination comparison
  always_comb begin
    matchA = '0;
    matchB = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      matchA[k] = entV[k] && (entRd[k] == id_rs1) && useA;
      matchB[k] = entV[k] && (entRd[k] == id_rs2) && useB;
    end
  end

`ifdef HZ_FORWARD_EN
  logic          entLd;
  logic [FW-1:0] selA;
  logic [FW-1:0] selB;

  assign hazard = entLd && (matchA[1] || matchB[1]);

  // youngest producer wins: scan oldest first, overwrite
  always_comb begin
    selA = '0;
    selB = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (matchA[k]) selA = FW'(k);
      if (matchB[k]) selB = FW'(k);
    end
  end

  // load flag of the EX entry only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) entLd <= 1'b0;
    else      entLd <= id_is_load;
  end

  // forward selects for the instruction entering EX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_a <= '0;
      fwd_b <= '0;
    end else if (advance && id_valid) begin
      fwd_a <= selA;
      fwd_b <= selB;
    end else begin
      fwd_a <= '0;
      fwd_b <= '0;
    end
  end
`else
  localparam logic [DEPTH:1] NEAR = {1'b0, {(DEPTH-1){1'b1}}};
  logic unusedLd;

  // WB stage is covered by write-before-read in the register file
  assign hazard   = |((matchA | matchB) & NEAR);
  assign unusedLd = id_is_load;
  assign fwd_a    = '0;
  assign fwd_b    = '0;
`endif

  assign stall   = id_valid && !ex_redirect && hazard;
  assign flush_d = ex_redirect;
  assign flush_e = ex_redirect;
  assign advance = !stall && !ex_redirect;

  // destination pipeline: EX loads from decode, others shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entV <= '0;
      for (int k = 1; k <= DEPTH; k++) entRd[k] <= '0;
    end else begin
      entV[1]  <= advance && id_valid && id_regwrite && (id_rd != '0);
      entRd[1] <= id_rd;
      for (int k = 2; k <= DEPTH; k++) begin
        entV[k]  <= entV[k-1];
        entRd[k] <= entRd[k-1];
      end
    end
  end

  // saturating stall-cycle counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        stall_cnt <= '0;
    else if (stall && ~&stall_cnt)   stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table-driven bench for hazard_scoreboard.
// Narrow counter width keeps the saturation check short.
module tb_hazard_scoreboard;

  localparam int DEPTH = 3;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
`ifdef HZ_FORWARD_EN
  localparam int PEND = 1;
`else
  localparam int PEND = DEPTH - 1;
`endif

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       rdr;
    logic       st;
    logic       fd;
    logic       fe;
    logic [1:0] fa;
    logic [1:0] fb;
    int         cnt;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_is_load;
  logic       ex_redirect;
  logic       stall;
  logic       flush_d;
  logic       flush_e;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [CW-1:0] stall_cnt;

  int nChecks = 0;
  int nFails  = 0;
  vec_t vecs[$];

  hazard_scoreboard #(.REGW(5), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect),
    .stall(stall), .flush_d(flush_d), .flush_e(flush_e),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    id_valid    = r.v;
    id_rs1      = r.rs1;
    id_rs2      = r.rs2;
    id_use_rs1  = r.u1;
    id_use_rs2  = r.u2;
    id_rd       = r.rd;
    id_regwrite = r.rw;
    id_is_load  = r.ld;
    ex_redirect = r.rdr;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic rw,
                       input logic ld);
    vec_t r;
    r = '{1'b1, rs1, rs2, u1, u2, rd, rw, ld, 1'b0,
          1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 0};
    drive(r);
  endtask

  initial begin
    int model;
    vec_t z;
    z = '{0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0};
`ifdef HZ_FORWARD_EN
    vecs.push_back('{1,0,0,0,0,5,1,0,0, 0,0,0,0,0,0});
    vecs.push_back('{1,5,0,1,0,0,0,0,0, 0,0,0,0,0,0});
    vecs.push_back('{1,0,0,0,0,7,1,1,0, 0,0,0,1,0,0});
    vecs.push_back('{1,5,7,1,1,0,0,0,0, 1,0,0,0,0,0});
    vecs.push_back('{1,5,7,1,1,0,0,0,0, 0,0,0,0,0,1});
    vecs.push_back('{1,0,0,0,0,3,1,0,0, 0,0,0,0,2,1});
    vecs.push_back('{1,0,0,0,0,3,1,0,0, 0,0,0,0,0,1});
    vecs.push_back('{1,3,3,1,1,0,0,0,0, 0,0,0,0,0,1});
    vecs.push_back('{1,0,0,0,0,0,1,0,0, 0,0,0,1,1,1});
    vecs.push_back('{1,0,3,1,1,0,0,0,0, 0,0,0,0,0,1});
    vecs.push_back('{1,0,0,0,0,7,1,1,0, 0,0,0,0,3,1});
    vecs.push_back('{1,7,0,1,0,0,0,0,1, 0,1,1,0,0,1});
    vecs.push_back('{1,7,0,1,0,0,0,0,0, 0,0,0,0,0,1});
    vecs.push_back('{0,0,0,0,0,0,0,0,0, 0,0,0,2,0,1});
    vecs.push_back('{0,0,0,0,0,0,0,0,0, 0,0,0,0,0,1});
`else
    vecs.push_back('{1,1,2,1,1,9,1,0,0, 0,0,0,0,0,0});
    vecs.push_back('{1,9,0,1,0,10,1,0,0, 1,0,0,0,0,0});
    vecs.push_back('{1,9,0,1,0,10,1,0,0, 1,0,0,0,0,1});
    vecs.push_back('{1,9,0,1,0,10,1,0,0, 0,0,0,0,0,2});
    vecs.push_back('{1,3,0,1,0,0,1,0,0, 0,0,0,0,0,2});
    vecs.push_back('{1,0,0,1,1,0,0,0,0, 0,0,0,0,0,2});
    vecs.push_back('{1,0,0,0,0,5,1,0,0, 0,0,0,0,0,2});
    vecs.push_back('{1,0,5,0,1,0,0,0,1, 0,1,1,0,0,2});
    vecs.push_back('{1,0,5,0,1,0,0,0,0, 1,0,0,0,0,2});
    vecs.push_back('{1,0,5,0,1,0,0,0,0, 0,0,0,0,0,3});
    vecs.push_back('{1,0,0,0,0,6,1,0,0, 0,0,0,0,0,3});
    vecs.push_back('{0,6,0,1,0,0,0,0,0, 0,0,0,0,0,3});
    vecs.push_back('{1,6,0,1,0,0,0,0,0, 1,0,0,0,0,3});
    vecs.push_back('{1,6,0,1,0,0,0,0,0, 0,0,0,0,0,4});
`endif

    rst = 1'b0;
    drive(z);
    #3;
    check("rst_stall", stall, 0);
    check("rst_flush_d", flush_d, 0);
    check("rst_fwd_a", fwd_a, 0);
    check("rst_fwd_b", fwd_b, 0);
    check("rst_cnt", stall_cnt, 0);
    nextCycle();
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("row%0d_stall", i), stall, vecs[i].st);
      check($sformatf("row%0d_flush_d", i), flush_d, vecs[i].fd);
      check($sformatf("row%0d_flush_e", i), flush_e, vecs[i].fe);
      check($sformatf("row%0d_fwd_a", i), fwd_a, vecs[i].fa);
      check($sformatf("row%0d_fwd_b", i), fwd_b, vecs[i].fb);
      check($sformatf("row%0d_cnt", i), stall_cnt, vecs[i].cnt);
      nextCycle();
    end

    // load-use pairs until the counter saturates
    model = vecs[vecs.size()-1].cnt;
    for (int it = 0; it < 16; it++) begin
      instr(0, 0, 0, 0, 7, 1, 1);
      @(negedge clk);
      check("sat_prod_stall", stall, 0);
      nextCycle();
      instr(0, 0, 7, 1, 0, 0, 0);
      for (int n = 0; n <= PEND; n++) begin
        @(negedge clk);
        check("sat_dep_stall", stall, (n < PEND) ? 1 : 0);
        check("sat_cnt", stall_cnt, model);
        if (n < PEND && model < CMAX) model++;
        nextCycle();
      end
    end
    @(negedge clk);
    check("cnt_saturated", stall_cnt, CMAX);
    nextCycle();

    // reset in the middle of a stall
    instr(0, 0, 0, 0, 9, 1, 1);
    nextCycle();
    instr(9, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("mid_stall_before", stall, 1);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_stall", stall, 0);
    check("mid_rst_cnt", stall_cnt, 0);
    check("mid_rst_fwd_a", fwd_a, 0);
    check("mid_rst_flush_d", flush_d, 0);
    ex_redirect = 1'b1;
    #1;
    check("rst_redir_flush_d", flush_d, 1);
    check("rst_redir_flush_e", flush_e, 1);
    check("rst_redir_stall", stall, 0);
    ex_redirect = 1'b0;
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_stall", stall, 0);
    check("post_rst_cnt", stall_cnt, 0);
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter: REGW, default 5, register-index width.
REQ-002 SHALL have parameter: DEPTH, default 3, number of tracked stages past decode (1=EX ... DEPTH=WB); legal range 2..6.
REQ-003 SHALL have parameter: CNT_W, default 16, stall-counter width.
REQ-004 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: id_valid in 1, instruction present in decode; id_rs1, id_rs2 in REGW, sources; id_use_rs1, id_use_rs2 in 1, source actually read.
REQ-007 SHALL have ports: id_rd in REGW, destination; id_regwrite in 1, writes rd; id_is_load in 1, result available only at stage 2.
REQ-008 SHALL have port: ex_redirect  in  1  taken branch/jump resolved in EX (the PC-select of execute).
REQ-009 SHALL have ports: stall out 1, hold fetch/decode; flush_d out 1, kill decode instruction; flush_e out 1, insert EX bubble.
REQ-010 SHALL have ports: fwd_a, fwd_b  out  clog2(DEPTH+1)  registered forward select for the instruction now in EX.
REQ-011 SHALL have port: stall_cnt  out  CNT_W  count of stalled cycles.

Function
REQ-012 SHALL keep per tracked stage k an entry {v, rd, ld}; entry k+1 loads entry k every cycle unconditionally.
REQ-013 SHALL load entry 1 with {id_valid & id_regwrite & (id_rd!=0), id_rd, id_is_load} when stall=0 and ex_redirect=0; otherwise v=0 (bubble).
REQ-014 SHALL define match_k(src) = entry_k.v & entry_k.rd==src & use & src!=0.
REQ-015 SHALL assert stall combinationally when id_valid and any used source has match_1 with entry_1.ld=1 (load-use), and ex_redirect=0.
REQ-016 SHALL give ex_redirect priority: flush_d=1 and flush_e=1 same cycle, stall forced 0.
REQ-017 SHALL, when decode advances, register fwd_a/fwd_b = smallest k with match_k (youngest producer), 0 if none; k means producer k stages ahead of consumer.
REQ-018 SHALL register fwd_a/fwd_b = 0 whenever entry 1 is loaded with a bubble.
REQ-019 SHALL increment stall_cnt each cycle stall=1, saturating at all-ones (no wrap).
REQ-020 SHALL treat x0 (index 0) as never hazardous, either as source or destination.
REQ-021 SHALL keep latency: stall/flush zero-cycle (combinational on current state), fwd one-cycle.

Reset
REQ-022 SHALL, while rst=0, clear all entry v bits, fwd_a, fwd_b, stall_cnt to 0, asynchronously.
REQ-023 SHALL, during and right after reset, drive stall=0, flush_d=0, flush_e=0 unless ex_redirect=1.
REQ-024 SHALL discard in-flight entries on reset mid-operation; no hazard from pre-reset instructions.

Configuration
REQ-025 SHALL compile forwarding in when macro HZ_FORWARD_EN is defined: behaviour per REQ-015..REQ-018.
REQ-026 SHALL, without HZ_FORWARD_EN, tie fwd_a/fwd_b to 0 and stall on any match_k for k<DEPTH (register file write-before-read covers k=DEPTH); load flag ignored.

Verification
REQ-027 SHALL cover: EX entry add x5, decode reads rs1=x5, no load -> stall=0, next cycle fwd_a=1 (with HZ_FORWARD_EN).
REQ-028 SHALL cover: lw x7 in EX, decode reads rs2=x7 -> stall=1 one cycle, stall_cnt 0->1, then fwd_b=2.
REQ-029 SHALL cover: producers of x3 in stages 1 and 2, decode reads x3 -> fwd_a=1 (youngest wins).
REQ-030 SHALL cover: load-use stall pending plus ex_redirect=1 same cycle -> stall=0, flush_d=1, flush_e=1, entry 1 bubble.
REQ-031 SHALL cover: id_rd=0 with regwrite, following read of x0 -> no stall, fwd_a=0; stall_cnt preset at all-ones stays all-ones on further stalls.
REQ-032 SHALL cover: without HZ_FORWARD_EN, add x9 then dependent read of x9 -> stall for DEPTH-1=2 cycles, fwd outputs 0; rst pulse mid-stall -> stall=0 immediately.
